// File: rtl/commit_group_decoder_pkg.sv
// commit_group_decoder_pkg: instruction, CSR-op and commit-type definitions shared by the commit group decoder
// len5_pkg: raw instruction word and RISC-V major opcodes
// csr_pkg: CSR operation encoding
// expipe_pkg: commit types and the serialising-type classification
package len5_pkg;
  typedef logic [31:0] instr_t;
  localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_LOAD_FP = 7'b0000111, OPC_MISC_MEM = 7'b0001111,
                         OPC_OP_IMM = 7'b0010011, OPC_AUIPC = 7'b0010111, OPC_OP_IMM_32 = 7'b0011011,
                         OPC_STORE = 7'b0100011, OPC_STORE_FP = 7'b0100111, OPC_OP = 7'b0110011,
                         OPC_LUI = 7'b0110111, OPC_OP_32 = 7'b0111011, OPC_MADD = 7'b1000011,
                         OPC_MSUB = 7'b1000111, OPC_NMSUB = 7'b1001011, OPC_NMADD = 7'b1001111,
                         OPC_OP_FP = 7'b1010011, OPC_BRANCH = 7'b1100011, OPC_JALR = 7'b1100111,
                         OPC_JAL = 7'b1101111, OPC_SYSTEM = 7'b1110011;
endpackage

package csr_pkg;
  typedef enum logic [2:0] {
    CSR_OP_NONE, CSR_OP_CSRRW, CSR_OP_CSRRS, CSR_OP_CSRRC, CSR_OP_CSRRWI, CSR_OP_CSRRSI, CSR_OP_CSRRCI
  } csr_op_t;
endpackage

package expipe_pkg;
  typedef enum logic [3:0] {
    COMM_TYPE_NONE, COMM_TYPE_INT_RF, COMM_TYPE_FP_RF, COMM_TYPE_INT_RF_FP, COMM_TYPE_LOAD,
    COMM_TYPE_LOAD_FP, COMM_TYPE_STORE, COMM_TYPE_JUMP, COMM_TYPE_BRANCH, COMM_TYPE_CSR,
    COMM_TYPE_ECALL, COMM_TYPE_EBREAK, COMM_TYPE_MRET, COMM_TYPE_WFI, COMM_TYPE_FENCE, COMM_TYPE_EXCEPT
  } comm_type_t;
  // one bit per commit type; set bits must commit alone and stall input until retired
  localparam logic [15:0] SERIAL_TYPES = 16'((1 << COMM_TYPE_EXCEPT) | (1 << COMM_TYPE_CSR) |
    (1 << COMM_TYPE_ECALL) | (1 << COMM_TYPE_EBREAK) | (1 << COMM_TYPE_MRET) |
    (1 << COMM_TYPE_WFI) | (1 << COMM_TYPE_FENCE));
  function automatic logic is_serializing(comm_type_t t);
    return SERIAL_TYPES[t];
  endfunction
endpackage

// File: rtl/commit_group_decoder_lane.sv
// commit_lane_decoder: combinational decode of one ROB-head instruction into commit type and CSR op
// instr_i/except_i in; comm_type_o/csr_op_o out. FP_EN=0 turns every F/D instruction into EXCEPT.
module commit_lane_decoder
  import len5_pkg::*, expipe_pkg::*, csr_pkg::*;
#(
  parameter bit FP_EN = 1'b1
) (
  input  instr_t     instr_i,
  input  logic       except_i,
  output comm_type_t comm_type_o,
  output csr_op_t    csr_op_o
);
  logic [2:0] f3;
  logic [4:0] f5;
  assign f3 = instr_i[14:12];
  assign f5 = instr_i[31:27];
  always_comb begin
    comm_type_o = COMM_TYPE_EXCEPT;
    csr_op_o = CSR_OP_NONE;
    case (instr_i[6:0])
      OPC_OP: if (instr_i[31:25] inside {7'h00, 7'h01, 7'h20}) comm_type_o = COMM_TYPE_INT_RF;
      OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32, OPC_LUI, OPC_AUIPC: comm_type_o = COMM_TYPE_INT_RF;
      OPC_LOAD: if (f3 != 3'b111) comm_type_o = COMM_TYPE_LOAD;
      OPC_STORE: if (!f3[2]) comm_type_o = COMM_TYPE_STORE;
      OPC_JAL, OPC_JALR: comm_type_o = COMM_TYPE_JUMP;
      OPC_BRANCH: if (f3[2:1] != 2'b01) comm_type_o = COMM_TYPE_BRANCH;
      OPC_MISC_MEM: comm_type_o = COMM_TYPE_FENCE;
      OPC_SYSTEM:
        case (f3)
          // privileged instructions need rd and rs1 zero
          3'b000: comm_type_o = instr_i[19:7] != '0 ? COMM_TYPE_EXCEPT
                              : instr_i[31:20] == 12'h000 ? COMM_TYPE_ECALL
                              : instr_i[31:20] == 12'h001 ? COMM_TYPE_EBREAK
                              : instr_i[31:20] == 12'h302 ? COMM_TYPE_MRET
                              : instr_i[31:20] == 12'h105 ? COMM_TYPE_WFI : COMM_TYPE_EXCEPT;
          3'b001: begin comm_type_o = COMM_TYPE_CSR; csr_op_o = CSR_OP_CSRRW; end
          3'b010: begin comm_type_o = COMM_TYPE_CSR; csr_op_o = CSR_OP_CSRRS; end
          3'b011: begin comm_type_o = COMM_TYPE_CSR; csr_op_o = CSR_OP_CSRRC; end
          3'b101: begin comm_type_o = COMM_TYPE_CSR; csr_op_o = CSR_OP_CSRRWI; end
          3'b110: begin comm_type_o = COMM_TYPE_CSR; csr_op_o = CSR_OP_CSRRSI; end
          3'b111: begin comm_type_o = COMM_TYPE_CSR; csr_op_o = CSR_OP_CSRRCI; end
          default: ;
        endcase
      OPC_LOAD_FP: if (FP_EN && f3 inside {3'b010, 3'b011}) comm_type_o = COMM_TYPE_LOAD_FP;
      OPC_STORE_FP: if (FP_EN && f3 inside {3'b010, 3'b011}) comm_type_o = COMM_TYPE_STORE;
      // FP results that may raise flags accumulate them into fflags via CSRRS
      OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD:
        if (FP_EN) begin comm_type_o = COMM_TYPE_FP_RF; csr_op_o = CSR_OP_CSRRS; end
      OPC_OP_FP:
        if (FP_EN)
          case (f5)
            5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01011, 5'b00100, 5'b00101, 5'b01000, 5'b11010, 5'b11110:
              begin comm_type_o = COMM_TYPE_FP_RF; csr_op_o = CSR_OP_CSRRS; end
            5'b10100, 5'b11000: begin comm_type_o = COMM_TYPE_INT_RF_FP; csr_op_o = CSR_OP_CSRRS; end
            5'b11100: comm_type_o = COMM_TYPE_INT_RF;
            default: ;
          endcase
      default: ;
    endcase
    if (except_i) begin
      comm_type_o = COMM_TYPE_EXCEPT;
      csr_op_o = CSR_OP_NONE;
    end
  end
endmodule

// File: rtl/commit_group_decoder.sv
// commit_group_decoder: decodes up to NUM_LANES ROB-head instructions into a serialisation-safe commit group
// in: clk_i, rst_i (async), flush_i, valid_i/instr_i/except_raised_i (lane 0 oldest), ready_i, serial_done_i
// out: ready_o, accept_cnt_o (lanes popped from ROB), valid_o/lane_valid_o/comm_type_o/csr_op_o (FIFO head)
module commit_group_decoder
  import len5_pkg::*, expipe_pkg::*, csr_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter bit FP_EN = 1'b1,
  parameter int BUF_DEPTH = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic [NUM_LANES-1:0]           valid_i,
  input  instr_t [NUM_LANES-1:0]         instr_i,
  input  logic [NUM_LANES-1:0]           except_raised_i,
  output logic                           ready_o,
  output logic [$clog2(NUM_LANES+1)-1:0] accept_cnt_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [NUM_LANES-1:0]           lane_valid_o,
  output comm_type_t [NUM_LANES-1:0]     comm_type_o,
  output csr_op_t [NUM_LANES-1:0]        csr_op_o,
  input  logic                           serial_done_i
);
  localparam int CW = $clog2(NUM_LANES + 1);
  localparam int AW = $clog2(BUF_DEPTH);
  typedef struct packed {
    logic [NUM_LANES-1:0]       lv;
    comm_type_t [NUM_LANES-1:0] ct;
    csr_op_t [NUM_LANES-1:0]    op;
  } grp_t;
  typedef enum logic {RUN, SERIAL} state_t;
  state_t state;
  comm_type_t [NUM_LANES-1:0] ct;
  csr_op_t [NUM_LANES-1:0] op;
  grp_t grp, head;
  grp_t mem [BUF_DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  logic [CW-1:0] k;
  logic stop, push, pop, full;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    commit_lane_decoder #(.FP_EN(FP_EN)) u_dec (
      .instr_i(instr_i[i]),
      .except_i(except_raised_i[i]),
      .comm_type_o(ct[i]),
      .csr_op_o(op[i])
    );
  end
  // group = leading valid run, cut before any serialising lane; a serialising lane 0 goes alone
  always_comb begin
    k = '0;
    stop = 1'b0;
    grp = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!stop && valid_i[i] && (i == 0 || !is_serializing(ct[i]))) begin
        k = CW'(i + 1);
        grp.lv[i] = 1'b1;
        grp.ct[i] = ct[i];
        grp.op[i] = op[i];
      end
      stop = stop || !valid_i[i] || is_serializing(ct[i]);
    end
  end
  assign full = cnt == (AW + 1)'(BUF_DEPTH);
  assign ready_o = !full && state == RUN && !flush_i;
  assign push = ready_o && valid_i[0];
  assign pop = valid_o && ready_i && !flush_i;
  assign accept_cnt_o = push ? k : '0;
  assign valid_o = cnt != '0;
  assign head = valid_o ? mem[rd] : '0;
  assign lane_valid_o = head.lv;
  assign comm_type_o = head.ct;
  assign csr_op_o = head.op;
  always_ff @(posedge clk_i) if (push) mem[wr] <= grp;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
      state <= RUN;
    end else if (flush_i) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
      state <= RUN;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      cnt <= cnt + (AW + 1)'(push) - (AW + 1)'(pop);
      // a group is serialising exactly when its lane 0 is
      if (state == RUN && push && is_serializing(ct[0])) state <= SERIAL;
      else if (state == SERIAL && serial_done_i) state <= RUN;
    end
  end
endmodule

// File: tb/tb_commit_group_decoder.sv
// tb_commit_group_decoder: directed scoreboard bench for commit_group_decoder (2 lanes, 2-entry FIFO, FP on and off)
module tb_commit_group_decoder;
  import len5_pkg::*;
  import expipe_pkg::*;
  import csr_pkg::*;
  localparam instr_t ADD = 32'h003100B3, LW = 32'h00012083, CSRRW = 32'h300110F3, FADD = 32'h003100D3,
                     FLT = 32'hA03110D3, FLW = 32'h00012087, JAL = 32'h000000EF, BEQ = 32'h00000063,
                     SW = 32'h00312023, LUI = 32'h000010B7, ECALL = 32'h00000073, BAD = 32'hFFFFFFFF;
  typedef struct packed {
    logic [1:0] lv;
    logic [7:0] ct;
    logic [5:0] op;
  } exp_t;
  localparam exp_t NOG = '0;
  logic clk = 1'b0;
  logic rst_i, flush_i, ready_i, serial_done_i;
  logic [1:0] valid_i, except_raised_i;
  instr_t [1:0] instr_i;
  logic ready_o, valid_o, n_ready_o, n_valid_o;
  logic [1:0] accept_cnt_o, lane_valid_o, n_accept_cnt_o, n_lane_valid_o;
  comm_type_t [1:0] comm_type_o, n_comm_type_o;
  csr_op_t [1:0] csr_op_o, n_csr_op_o;
  exp_t q[$];
  int n_cmp = 0, n_err = 0, exp2 = -1;
  always #5 clk = ~clk;
  commit_group_decoder #(.NUM_LANES(2), .FP_EN(1'b1), .BUF_DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .instr_i(instr_i),
    .except_raised_i(except_raised_i), .ready_o(ready_o), .accept_cnt_o(accept_cnt_o), .valid_o(valid_o),
    .ready_i(ready_i), .lane_valid_o(lane_valid_o), .comm_type_o(comm_type_o), .csr_op_o(csr_op_o),
    .serial_done_i(serial_done_i)
  );
  commit_group_decoder #(.NUM_LANES(2), .FP_EN(1'b0), .BUF_DEPTH(2)) dut_nofp (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .instr_i(instr_i),
    .except_raised_i(except_raised_i), .ready_o(n_ready_o), .accept_cnt_o(n_accept_cnt_o), .valid_o(n_valid_o),
    .ready_i(ready_i), .lane_valid_o(n_lane_valid_o), .comm_type_o(n_comm_type_o), .csr_op_o(n_csr_op_o),
    .serial_done_i(serial_done_i)
  );
  function automatic exp_t mk(logic [1:0] lv, comm_type_t c0, comm_type_t c1, csr_op_t o0, csr_op_t o1);
    exp_t e;
    e.lv = lv;
    e.ct = {c1, c0};
    e.op = {o1, o0};
    return e;
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // drive one cycle, check handshake and head group at the negedge, update the scoreboard
  task automatic cyc(input string tag, input logic [1:0] v, input instr_t i0, input instr_t i1, input logic rdy,
                     input logic exp_rdy, input logic [1:0] exp_cnt, input exp_t g);
    exp_t e;
    valid_i = v;
    instr_i = {i1, i0};
    ready_i = rdy;
    @(negedge clk);
    chk({tag, ".ready"}, 16'(ready_o), 16'(exp_rdy));
    chk({tag, ".cnt"}, 16'(accept_cnt_o), 16'(exp_cnt));
    chk({tag, ".valid"}, 16'(valid_o), 16'(q.size() != 0));
    if (q.size() == 0) chk({tag, ".empty_out"}, 16'({lane_valid_o, comm_type_o, csr_op_o}), 16'(0));
    if (valid_o && ready_i && !flush_i && q.size() != 0) begin
      e = q.pop_front();
      chk({tag, ".lv"}, 16'(lane_valid_o), 16'(e.lv));
      chk({tag, ".ct"}, 16'(comm_type_o), 16'(e.ct));
      chk({tag, ".op"}, 16'(csr_op_o), 16'(e.op));
    end
    if (flush_i) q.delete();
    if (exp_cnt != 0) q.push_back(g);
    if (exp2 >= 0) chk({tag, ".nofp_cnt"}, 16'(n_accept_cnt_o), 16'(exp2));
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input string tag);
    valid_i = 2'b00;
    rst_i = 1'b1;
    #1;
    chk({tag, ".valid"}, 16'(valid_o), 16'(0));
    chk({tag, ".lv"}, 16'(lane_valid_o), 16'(0));
    chk({tag, ".ct"}, 16'(comm_type_o), 16'(COMM_TYPE_NONE));
    chk({tag, ".op"}, 16'(csr_op_o), 16'(CSR_OP_NONE));
    chk({tag, ".ready"}, 16'(ready_o), 16'(1));
    chk({tag, ".cnt"}, 16'(accept_cnt_o), 16'(0));
    q.delete();
    @(posedge clk);
    #1 rst_i = 1'b0;
  endtask
  initial begin
    exp_t g;
    g = mk(2'b11, COMM_TYPE_INT_RF, COMM_TYPE_LOAD, CSR_OP_NONE, CSR_OP_NONE);
    rst_i = 1'b1; flush_i = 1'b0; ready_i = 1'b0; serial_done_i = 1'b0;
    valid_i = 2'b00; except_raised_i = 2'b00; instr_i = '0;
    do_reset("por");
    cyc("idle", 2'b00, ADD, LW, 1, 1, 0, NOG);
    cyc("add_lw", 2'b11, ADD, LW, 1, 1, 2, g);
    cyc("add_csr", 2'b11, ADD, CSRRW, 1, 1, 1, mk(2'b01, COMM_TYPE_INT_RF, COMM_TYPE_NONE, CSR_OP_NONE, CSR_OP_NONE));
    cyc("csr_alone", 2'b11, CSRRW, LW, 1, 1, 1, mk(2'b01, COMM_TYPE_CSR, COMM_TYPE_NONE, CSR_OP_CSRRW, CSR_OP_NONE));
    cyc("serial_hold", 2'b11, LW, ADD, 1, 0, 0, NOG);
    serial_done_i = 1'b1;
    cyc("serial_done", 2'b11, LW, ADD, 1, 0, 0, NOG);
    serial_done_i = 1'b0;
    cyc("serial_exit", 2'b11, LW, ADD, 1, 1, 2, mk(2'b11, COMM_TYPE_LOAD, COMM_TYPE_INT_RF, CSR_OP_NONE, CSR_OP_NONE));
    serial_done_i = 1'b1;
    cyc("done_in_run", 2'b00, ADD, LW, 1, 1, 0, NOG);
    serial_done_i = 1'b0;
    cyc("pre_rst", 2'b11, ADD, LW, 1, 1, 2, g);
    do_reset("mid_rst");
    exp2 = 1;
    cyc("fadd", 2'b11, FADD, ADD, 1, 1, 2, mk(2'b11, COMM_TYPE_FP_RF, COMM_TYPE_INT_RF, CSR_OP_CSRRS, CSR_OP_NONE));
    exp2 = -1;
    chk("nofp.valid", 16'(n_valid_o), 16'(1));
    chk("nofp.lv", 16'(n_lane_valid_o), 16'(2'b01));
    chk("nofp.ct", 16'(n_comm_type_o), 16'({COMM_TYPE_NONE, COMM_TYPE_EXCEPT}));
    chk("nofp.ready", 16'(n_ready_o), 16'(0));
    cyc("flt_flw", 2'b11, FLT, FLW, 1, 1, 2, mk(2'b11, COMM_TYPE_INT_RF_FP, COMM_TYPE_LOAD_FP, CSR_OP_CSRRS, CSR_OP_NONE));
    cyc("jal_beq", 2'b11, JAL, BEQ, 1, 1, 2, mk(2'b11, COMM_TYPE_JUMP, COMM_TYPE_BRANCH, CSR_OP_NONE, CSR_OP_NONE));
    cyc("sw_lui", 2'b11, SW, LUI, 1, 1, 2, mk(2'b11, COMM_TYPE_STORE, COMM_TYPE_INT_RF, CSR_OP_NONE, CSR_OP_NONE));
    cyc("add_ecall", 2'b11, ADD, ECALL, 1, 1, 1, mk(2'b01, COMM_TYPE_INT_RF, COMM_TYPE_NONE, CSR_OP_NONE, CSR_OP_NONE));
    cyc("ecall", 2'b11, ECALL, ADD, 1, 1, 1, mk(2'b01, COMM_TYPE_ECALL, COMM_TYPE_NONE, CSR_OP_NONE, CSR_OP_NONE));
    serial_done_i = 1'b1;
    cyc("ecall_done", 2'b00, ADD, ADD, 1, 0, 0, NOG);
    serial_done_i = 1'b0;
    except_raised_i = 2'b10;
    cyc("exc_lane1", 2'b11, ADD, ADD, 1, 1, 1, mk(2'b01, COMM_TYPE_INT_RF, COMM_TYPE_NONE, CSR_OP_NONE, CSR_OP_NONE));
    except_raised_i = 2'b01;
    cyc("exc_lane0", 2'b11, ADD, ADD, 1, 1, 1, mk(2'b01, COMM_TYPE_EXCEPT, COMM_TYPE_NONE, CSR_OP_NONE, CSR_OP_NONE));
    except_raised_i = 2'b00;
    serial_done_i = 1'b1;
    cyc("exc_done", 2'b00, ADD, ADD, 1, 0, 0, NOG);
    serial_done_i = 1'b0;
    cyc("gap_lane0", 2'b10, ADD, ADD, 1, 1, 0, NOG);
    cyc("bad", 2'b01, BAD, ADD, 1, 1, 1, mk(2'b01, COMM_TYPE_EXCEPT, COMM_TYPE_NONE, CSR_OP_NONE, CSR_OP_NONE));
    serial_done_i = 1'b1;
    cyc("bad_done", 2'b00, ADD, ADD, 1, 0, 0, NOG);
    serial_done_i = 1'b0;
    cyc("fill0", 2'b11, ADD, LW, 0, 1, 2, g);
    cyc("fill1", 2'b11, ADD, LW, 0, 1, 2, g);
    cyc("full", 2'b11, ADD, LW, 0, 0, 0, NOG);
    cyc("full_pop", 2'b11, ADD, LW, 1, 0, 0, NOG);
    cyc("recover", 2'b11, ADD, LW, 1, 1, 2, g);
    cyc("drain0", 2'b00, ADD, LW, 1, 1, 0, NOG);
    cyc("drain1", 2'b00, ADD, LW, 1, 1, 0, NOG);
    cyc("pre_flush0", 2'b11, ADD, LW, 0, 1, 2, g);
    cyc("pre_flush1", 2'b11, CSRRW, LW, 0, 1, 1, mk(2'b01, COMM_TYPE_CSR, COMM_TYPE_NONE, CSR_OP_CSRRW, CSR_OP_NONE));
    flush_i = 1'b1;
    serial_done_i = 1'b1;
    cyc("flush", 2'b11, ADD, LW, 1, 0, 0, NOG);
    flush_i = 1'b0;
    serial_done_i = 1'b0;
    cyc("post_flush", 2'b11, ADD, LW, 1, 1, 2, g);
    cyc("post_flush2", 2'b00, ADD, LW, 1, 1, 0, NOG);
    do_reset("end_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
